// File: rtl/xmem_port_pkg.sv
// xmem_port_pkg: shared constants for the Versat memory-port sequencer.
package xmem_port_pkg;
    localparam int XMEM_ADDR_W = 10;
    localparam logic XMEM_RD = 1'b0;
    localparam logic XMEM_WR = 1'b1;
    localparam int XMEM_RAM_LAT_MIN = 1;
    localparam int XMEM_RAM_LAT_MAX = 2;
endpackage

// File: rtl/xdelay_line.sv
// xdelay_line: programmable-depth address/enable delay built on a circular buffer.
module xdelay_line #(
    parameter int AW      = 10,
    parameter int DELAY_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [DELAY_W-1:0] delay,
    input  logic [AW-1:0]      addr_i,
    input  logic               en_i,
    output logic [AW-1:0]      addr_o,
    output logic               en_o
);
    localparam int DEPTH = 1 << DELAY_W;

    logic [AW-1:0]      addr_mem [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [DELAY_W-1:0] wptr_q;
    logic [DELAY_W-1:0] rptr;

    assign rptr = wptr_q - delay;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            wptr_q <= '0;
        end else if (!stall) begin
            vld_q[wptr_q] <= en_i;
            wptr_q        <= wptr_q + DELAY_W'(1);
        end
    end

    // Address payload needs no reset: it is only consumed alongside a set valid bit.
    always_ff @(posedge clk) begin
        if (!stall) addr_mem[wptr_q] <= addr_i;
    end

    assign en_o   = (delay == '0) ? en_i   : vld_q[rptr];
    assign addr_o = (delay == '0) ? addr_i : addr_mem[rptr];
endmodule

// File: rtl/xmem_port.sv
// xmem_port: aligns the address-generator stream to the datapath and drives one RAM port,
// returning read data with a strobe and reporting when every access has retired.
module xmem_port
    import xmem_port_pkg::*;
#(
    parameter int MEM_ADDR_W = XMEM_ADDR_W,
    parameter int DATA_W     = 32,
    parameter int DELAY_W    = 5,
    parameter int RAM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  pause,
    input  logic                  cfg_wr,
    input  logic [DELAY_W-1:0]    cfg_delay,
    input  logic [MEM_ADDR_W-1:0] ag_addr,
    input  logic                  ag_mem_en,
    input  logic                  ag_done,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [MEM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    output logic                  done,
    output logic [MEM_ADDR_W:0]   xfer_cnt
);
    localparam int LAT = (RAM_LAT < XMEM_RAM_LAT_MIN) ? XMEM_RAM_LAT_MIN :
                         (RAM_LAT > XMEM_RAM_LAT_MAX) ? XMEM_RAM_LAT_MAX : RAM_LAT;
    localparam int IW  = DELAY_W + 2;

    logic                  dl_en;
    logic [MEM_ADDR_W-1:0] dl_addr;
    logic                  s1_en_q;
    logic [MEM_ADDR_W-1:0] s1_addr_q;
    logic [LAT-1:0]        rv_q;
    logic [LAT:0]          rv_d;
    logic [DATA_W-1:0]     out_data_q;
    logic                  out_valid_q;
    logic                  done_q;
    logic [IW-1:0]         infl_q, infl_d;
    logic [MEM_ADDR_W:0]   xfer_q, xfer_d;
    logic                  push;

    xdelay_line #(.AW(MEM_ADDR_W), .DELAY_W(DELAY_W)) u_dline (
        .clk    (clk),
        .rst    (rst),
        .stall  (pause),
        .delay  (cfg_delay),
        .addr_i (ag_addr),
        .en_i   (ag_mem_en),
        .addr_o (dl_addr),
        .en_o   (dl_en)
    );

    assign push      = ag_mem_en & ~pause;
    assign ram_en    = s1_en_q & ~pause;
    assign ram_we    = ram_en & (cfg_wr == XMEM_WR);
    assign ram_addr  = s1_addr_q;
    assign ram_wdata = in_data;
    assign rv_d      = {rv_q, ram_en & (cfg_wr == XMEM_RD)};
    // Writes retire when issued, reads when their data is handed back.
    assign infl_d    = infl_q + IW'(push) - IW'(ram_we) - IW'(out_valid_q);
    assign xfer_d    = (init & done_q) ? '0 :
                       (ram_en & ~&xfer_q) ? xfer_q + 1'b1 : xfer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_en_q     <= 1'b0;
            s1_addr_q   <= '0;
            rv_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            infl_q      <= '0;
            done_q      <= 1'b1;
            xfer_q      <= '0;
        end else begin
            if (!pause) begin
                s1_en_q   <= dl_en;
                s1_addr_q <= dl_addr;
            end
            rv_q        <= rv_d[LAT-1:0];
            out_valid_q <= rv_q[LAT-1];
            if (rv_q[LAT-1]) out_data_q <= ram_rdata;
            infl_q      <= infl_d;
            done_q      <= ag_done & (infl_q == '0) & ~ag_mem_en;
            xfer_q      <= xfer_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign xfer_cnt  = xfer_q;
endmodule
